// File: rtl/question_period.sv
// Quiz question timer: BCD elapsed-seconds counter with buzzer handoff,
// answer accept/reject handling and timeout, driving four 7-seg digits.
module question_period #(
    parameter int TIME_LIMIT = 30
) (
    input  logic       Clk100M,
    input  logic       Rst,
    input  logic       Clk1Hz,
    input  logic       startSig,
    input  logic       buzzSig,
    input  logic       postSig,
    input  logic       stopCount,
    output logic       answerSig,
    output logic       timeoutSig,
    output logic [7:0] countSeg0,
    output logic [7:0] countSeg1,
    output logic [7:0] countSeg2,
    output logic [7:0] countSeg3
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        WAIT_ANS,
        DONE,
        EXPIRED
    } state_t;

    localparam logic [15:0] LIMIT_BCD = {
        4'(TIME_LIMIT / 1000 % 10),
        4'(TIME_LIMIT / 100 % 10),
        4'(TIME_LIMIT / 10 % 10),
        4'(TIME_LIMIT % 10)
    };

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-low {dp,g,f,e,d,c,b,a}
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic        ans_n;
    logic        sync1, sync2, sync3;
    logic        buzz_edge;

    assign buzz_edge = sync2 & ~sync3;
    assign cnt_inc   = bcd_inc(cnt);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ans_n   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (startSig) state_n = COUNT;
            end
            COUNT: begin
                if (startSig) begin
                    cnt_n = '0;
                end else if (Clk1Hz) begin
                    // Tick wins over a coincident buzz; limit check first
                    cnt_n = cnt_inc;
                    if (cnt_inc == LIMIT_BCD) begin
                        state_n = EXPIRED;
                    end else if (buzz_edge) begin
                        state_n = WAIT_ANS;
                        ans_n   = 1'b1;
                    end
                end else if (buzz_edge) begin
                    state_n = WAIT_ANS;
                    ans_n   = 1'b1;
                end
            end
            WAIT_ANS: begin
                if (startSig) begin
                    state_n = COUNT;
                    cnt_n   = '0;
                end else if (stopCount) begin
                    state_n = DONE;
                end else if (postSig) begin
                    state_n = COUNT;
                end
            end
            DONE, EXPIRED: begin
                if (startSig) begin
                    state_n = COUNT;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk100M or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            answerSig  <= 1'b0;
            timeoutSig <= 1'b0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            countSeg0  <= 8'hC0;
            countSeg1  <= 8'hC0;
            countSeg2  <= 8'hC0;
            countSeg3  <= 8'hC0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            answerSig  <= ans_n;
            timeoutSig <= (state_n == EXPIRED);
            sync1      <= buzzSig;
            sync2      <= sync1;
            sync3      <= sync2;
            countSeg0  <= seg7(cnt_n[3:0]);
            countSeg1  <= seg7(cnt_n[7:4]);
            countSeg2  <= seg7(cnt_n[11:8]);
            countSeg3  <= seg7(cnt_n[15:12]);
        end
    end

endmodule

// File: tb/tb_question_period.sv
// Bench for question_period: random and directed stimulus, reference model
// feeding a per-cycle expectation queue drained by an independent monitor.
module tb_question_period;

    localparam int LIMIT = 5;

    logic       Clk100M = 1'b0;
    logic       Rst = 1'b0;
    logic       Clk1Hz = 1'b0;
    logic       startSig = 1'b0;
    logic       buzzSig = 1'b0;
    logic       postSig = 1'b0;
    logic       stopCount = 1'b0;
    logic       answerSig;
    logic       timeoutSig;
    logic [7:0] countSeg0, countSeg1, countSeg2, countSeg3;

    question_period #(.TIME_LIMIT(LIMIT)) dut (
        .Clk100M   (Clk100M),
        .Rst       (Rst),
        .Clk1Hz    (Clk1Hz),
        .startSig  (startSig),
        .buzzSig   (buzzSig),
        .postSig   (postSig),
        .stopCount (stopCount),
        .answerSig (answerSig),
        .timeoutSig(timeoutSig),
        .countSeg0 (countSeg0),
        .countSeg1 (countSeg1),
        .countSeg2 (countSeg2),
        .countSeg3 (countSeg3)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct {
        logic ans;
        logic tmo;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Stimulus intent for the next cycle
    logic st = 0, po = 0, sp = 0, bz = 0, rs = 0;
    int   tick_ph = 0;

    // Reference model
    localparam int M_IDLE = 0, M_COUNT = 1, M_WAIT = 2, M_DONE = 3, M_EXP = 4;
    int       m_state = M_IDLE;
    int       m_cnt = 0;
    logic [2:0] m_hist = 3'b000;

    function automatic logic [7:0] digit_code(input int d);
        logic [7:0] t [10];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return t[d];
    endfunction

    function automatic logic [31:0] seg_word(input int c);
        return {digit_code(c / 1000 % 10), digit_code(c / 100 % 10),
                digit_code(c / 10 % 10), digit_code(c % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        logic buzz_seen;
        e.ans = 1'b0;
        if (Rst) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            m_hist  = 3'b000;
        end else begin
            // buzz rose two samples ago after being low the sample before
            buzz_seen = m_hist[1] & ~m_hist[2];
            m_hist    = {m_hist[1:0], buzzSig};
            if (m_state == M_IDLE) begin
                if (startSig) begin
                    m_state = M_COUNT;
                    m_cnt   = 0;
                end
            end else if (m_state == M_COUNT) begin
                if (startSig) begin
                    m_cnt = 0;
                end else begin
                    if (Clk1Hz) m_cnt = m_cnt + 1;
                    if (Clk1Hz && m_cnt == LIMIT) begin
                        m_state = M_EXP;
                    end else if (buzz_seen) begin
                        m_state = M_WAIT;
                        e.ans   = 1'b1;
                    end
                end
            end else if (m_state == M_WAIT) begin
                if (startSig) begin
                    m_state = M_COUNT;
                    m_cnt   = 0;
                end else if (stopCount) begin
                    m_state = M_DONE;
                end else if (postSig) begin
                    m_state = M_COUNT;
                end
            end else begin
                if (startSig) begin
                    m_state = M_COUNT;
                    m_cnt   = 0;
                end
            end
        end
        e.tmo = (m_state == M_EXP);
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic step();
        logic newrst;
        @(negedge Clk100M);
        newrst    = rs && !Rst;
        startSig  = st;
        postSig   = po;
        stopCount = sp;
        buzzSig   = bz;
        Rst       = rs;
        tick_ph   = (tick_ph == 99) ? 0 : tick_ph + 1;
        Clk1Hz    = (tick_ph == 99);
        if (newrst) begin
            #1;
            chk("async_rst_segs", {countSeg3, countSeg2, countSeg1, countSeg0},
                32'hC0C0C0C0);
            chk("async_rst_answer", {31'b0, answerSig}, 32'd0);
            chk("async_rst_timeout", {31'b0, timeoutSig}, 32'd0);
        end
        model_edge();
        st = 1'b0;
        po = 1'b0;
        sp = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            step();
            if (Clk1Hz) k++;
        end
    endtask

    task automatic wait_ph(input int p);
        while (tick_ph != p) step();
    endtask

    task automatic settle();
        @(posedge Clk100M);
        #1;
    endtask

    task automatic look(input string nm, input logic [31:0] segs,
                        input logic tmo);
        chk({nm, "_segs"}, {countSeg3, countSeg2, countSeg1, countSeg0}, segs);
        chk({nm, "_timeout"}, {31'b0, timeoutSig}, {31'b0, tmo});
    endtask

    // Monitor: one expectation per clock edge once stimulus has begun
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk100M);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("answerSig", {31'b0, answerSig}, {31'b0, e.ans});
                chk("timeoutSig", {31'b0, timeoutSig}, {31'b0, e.tmo});
                chk("count_segs", {countSeg3, countSeg2, countSeg1, countSeg0},
                    seg_word(e.cnt));
            end
        end
    end

    initial begin
        rs = 1; steps(2);
        rs = 0; steps(3);
        settle();
        look("reset", 32'hC0C0C0C0, 1'b0);

        // Timeout with no buzz, then further ticks change nothing
        st = 1; step();
        run_ticks(5);
        settle();
        look("timeout", 32'hC0C0C092, 1'b1);
        run_ticks(2);
        settle();
        look("timeout_hold", 32'hC0C0C092, 1'b1);

        // Buzz handoff at count 2, count frozen across ticks
        st = 1; step();
        run_ticks(2);
        wait_ph(50);
        bz = 1; steps(10);
        run_ticks(3);
        settle();
        look("handoff", 32'hC0C0C0A4, 1'b0);

        // Buzz in WAIT_ANS ignored, resume to expiry, buzz in EXPIRED ignored
        bz = 0; steps(5);
        bz = 1; steps(5);
        bz = 0; steps(5);
        po = 1; step();
        run_ticks(3);
        settle();
        look("resume", 32'hC0C0C092, 1'b1);
        bz = 1; steps(10);
        bz = 0; steps(5);

        // Accept: DONE freezes count, start restarts from zero
        st = 1; step();
        run_ticks(2);
        wait_ph(40);
        bz = 1; steps(10);
        bz = 0;
        sp = 1; step();
        run_ticks(2);
        settle();
        look("accept", 32'hC0C0C0A4, 1'b0);
        st = 1; step();
        settle();
        look("restart", 32'hC0C0C0C0, 1'b0);
        run_ticks(1);
        settle();
        look("recount", 32'hC0C0C0F9, 1'b0);

        // Buzz edge on the limit tick, then on the 3rd tick
        st = 1; step();
        run_ticks(4);
        wait_ph(96);
        bz = 1; steps(3);
        steps(20);
        settle();
        look("collide_limit", 32'hC0C0C092, 1'b1);
        bz = 0; steps(5);
        st = 1; step();
        run_ticks(2);
        wait_ph(96);
        bz = 1; steps(3);
        steps(10);
        settle();
        look("collide_mid", 32'hC0C0C0B0, 1'b0);

        // Async reset during WAIT_ANS, then idle until start
        bz = 0; steps(3);
        rs = 1; step();
        rs = 0; run_ticks(2);
        settle();
        look("post_reset_idle", 32'hC0C0C0C0, 1'b0);

        // Random traffic
        for (int i = 0; i < 8000; i++) begin
            st = ($urandom_range(0, 599) == 0);
            po = ($urandom_range(0, 39) == 0);
            sp = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 29) == 0) bz = ~bz;
            rs = ($urandom_range(0, 2999) == 0);
            step();
        end
        rs = 0; bz = 0;
        steps(2);

        repeat (3) @(posedge Clk100M);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/question_period.md
QUESTION_PERIOD -- requirements
Module: question_period

Interface
REQ-001 Parameter TIME_LIMIT, default 30, meaning: question period length in seconds; legal range 1..9999.
REQ-002 Clk100M  input  1  system clock; all state changes on its rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-high.
REQ-004 Clk1Hz  input  1  one-Clk100M-cycle tick, once per second, synchronous to Clk100M.
REQ-005 startSig  input  1  one-cycle pulse that starts a new question period.
REQ-006 buzzSig  input  1  asynchronous contestant buzzer level.
REQ-007 postSig  input  1  one-cycle pulse from the answer block: answer rejected, resume counting.
REQ-008 stopCount  input  1  level from the answer block: answer accepted, end the round.
REQ-009 answerSig  output  1  one-cycle pulse handing control to the answer block.
REQ-010 timeoutSig  output  1  high while in EXPIRED.
REQ-011 countSeg0..countSeg3  output  8 each  seven-segment codes of elapsed seconds; countSeg0 is the least significant digit.

Function
REQ-012 The FSM SHALL have states IDLE, COUNT, WAIT_ANS, DONE and EXPIRED, with all outputs registered.
REQ-013 Elapsed time SHALL be held as 4 BCD digits (0000..9999); each digit wraps from 9 to 0 with carry into the next digit.
REQ-014 IDLE: count held at 0000; startSig -> COUNT.
REQ-015 COUNT: each Clk1Hz tick increments the count by 1.
REQ-016 COUNT: when the count reaches TIME_LIMIT on a tick -> EXPIRED in the same cycle; the displayed count is TIME_LIMIT.
REQ-017 buzzSig SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-018 COUNT: a detected buzz edge -> WAIT_ANS, with answerSig high for exactly one cycle.
REQ-019 Buzz latency: answerSig is high on the 3rd Clk100M rising edge after buzzSig is first sampled high.
REQ-020 Buzz edges detected in any state other than COUNT SHALL be ignored and not queued.
REQ-021 WAIT_ANS: the count is frozen and Clk1Hz ticks are ignored.
REQ-022 WAIT_ANS: postSig -> COUNT; counting resumes from the frozen value on the next tick.
REQ-023 WAIT_ANS: stopCount high -> DONE.
REQ-024 WAIT_ANS: if stopCount and postSig are high in the same cycle, stopCount wins.
REQ-025 DONE: the count is frozen and displayed; startSig -> COUNT with count reset to 0000.
REQ-026 EXPIRED: timeoutSig=1 and the count is frozen; startSig -> COUNT with count 0000 and timeoutSig=0.
REQ-027 COUNT, tick and buzz edge in the same cycle: the tick is applied first; if the limit is reached -> EXPIRED and no answerSig, else -> WAIT_ANS with answerSig.
REQ-028 startSig in COUNT or WAIT_ANS SHALL restart: count 0000, state COUNT, no answerSig.
REQ-029 Segment codes SHALL be active-low {dp,g,f,e,d,c,b,a}, dp off.
REQ-030 Digit codes 0-9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex); leading zeros are displayed.

Reset
REQ-031 Rst SHALL force IDLE immediately, independent of Clk100M.
REQ-032 Rst SHALL set the count to 0000, answerSig=0, timeoutSig=0, all countSegN=C0, and clear the synchronizer and edge registers.
REQ-033 Rst asserted mid-operation SHALL abandon any pending buzz or answer handshake; after release the block waits in IDLE for startSig.

Verification (TIME_LIMIT=5, Clk1Hz every 100 cycles)
REQ-034 Timeout: startSig, no buzz, 5 ticks -> countSeg0=92, countSeg1..3=C0, timeoutSig=1; further ticks -> no change.
REQ-035 Buzz handoff: startSig, 2 ticks, buzzSig raised -> answerSig is a single pulse on the 3rd edge; count stays at 2 (countSeg0=A4) across later ticks.
REQ-036 Resume: after REQ-035, postSig pulse then 3 ticks -> EXPIRED with count 5; a buzz during WAIT_ANS or EXPIRED -> no answerSig.
REQ-037 Accept: after REQ-035, stopCount=1 -> DONE, count 2 frozen; startSig -> count 0000 and counting resumes.
REQ-038 Collision: buzz edge coinciding with the 5th tick -> EXPIRED, answerSig never asserted; same coincidence on the 3rd tick -> count 3 with answerSig pulse.
REQ-039 Async reset: Rst pulsed between clock edges while in WAIT_ANS -> outputs reach reset values before the next edge; startSig is required to count again.
